// File: rtl/parking_pkg.sv
// Shared types and constants for the parking controller: FSM states, slot
// indexing, timer limits and small occupancy helpers.
package parking_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int MAX_SEC   = 59;
  localparam int MAX_MIN   = 59;

  typedef logic [1:0] slot_idx_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_GATE = 2'd1,
    EXIT_GATE  = 2'd2
  } state_t;

  function automatic logic [2:0] free_count(input logic [NUM_SLOTS-1:0] occ);
    free_count = 3'(NUM_SLOTS);
    for (int i = 0; i < NUM_SLOTS; i++)
      if (occ[i]) free_count = free_count - 3'd1;
  endfunction

  // Lowest free index; 0 when every slot is taken.
  function automatic slot_idx_t lowest_free(input logic [NUM_SLOTS-1:0] occ);
    lowest_free = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (!occ[i]) lowest_free = slot_idx_t'(i);
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Per-slot parking-duration timer in mm:ss, advancing on the one-second tick
// while the slot is occupied and saturating at 59:59.
module slot_timer
  import parking_pkg::*;
(
  input  logic       clk_500Hz,
  input  logic       clear,
  input  logic       run,
  input  logic       tick,
  output logic [5:0] minutes,
  output logic [5:0] seconds
);

  always_ff @(posedge clk_500Hz) begin
    if (clear) begin
      minutes <= '0;
      seconds <= '0;
    end else if (run && tick) begin
      if (seconds == 6'(MAX_SEC)) begin
        if (minutes != 6'(MAX_MIN)) begin
          seconds <= '0;
          minutes <= minutes + 6'd1;
        end
      end else begin
        seconds <= seconds + 6'd1;
      end
    end
  end

endmodule

// File: rtl/parking_controller.sv
// Four-slot parking controller: gate sequencing, slot allocation, per-slot
// timers and display mux. Optional fee output is enabled with PARKING_FEE_EN.
//
//  state      | meaning
//  -----------+-------------------------------------------------------
//  IDLE       | gate closed, serving exit (priority) or entry requests
//  ENTRY_GATE | gate open after an admitted car, requests ignored
//  EXIT_GATE  | gate open after a departing car, requests ignored
module parking_controller
  import parking_pkg::*;
#(
  parameter int TICKS_PER_SEC  = 500,
  parameter int GATE_OPEN_SECS = 3
) (
  input  logic       clk_500Hz,
  input  logic       reset,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [1:0] exit_slot,
  input  logic       show_time,
  input  logic [1:0] sel_slot,
  output logic       gate_open,
  output logic       entry_ack,
  output logic       exit_ack,
  output logic       exit_err,
  output logic       full,
  output logic [3:0] occupancy,
  output logic       mode,
  output logic [2:0] capacity,
  output logic [1:0] empty_slot,
  output logic [5:0] minutes,
  output logic [5:0] seconds
`ifdef PARKING_FEE_EN
  ,
  output logic [7:0] fee,
  output logic       fee_valid
`endif
);

  localparam int GATE_CYCLES = GATE_OPEN_SECS * TICKS_PER_SEC;
  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  state_t                 state, state_nxt;
  logic [GW-1:0]          gate_cnt, gate_cnt_nxt;
  logic [NUM_SLOTS-1:0]   occ_nxt;
  logic [PW-1:0]          presc_cnt;
  logic                   tick;
  logic [5:0]             tm_min [NUM_SLOTS];
  logic [5:0]             tm_sec [NUM_SLOTS];

  assign tick = (presc_cnt == PW'(TICKS_PER_SEC - 1));

  always_ff @(posedge clk_500Hz) begin
    if (reset || tick) presc_cnt <= '0;
    else               presc_cnt <= presc_cnt + 1'b1;
  end

  assign capacity   = free_count(occupancy);
  assign empty_slot = lowest_free(occupancy);
  assign full       = (capacity == 3'd0);
  assign gate_open  = (state != IDLE);

  always_ff @(posedge clk_500Hz) begin
    if (reset) begin
      state     <= IDLE;
      gate_cnt  <= '0;
      occupancy <= '0;
    end else begin
      state     <= state_nxt;
      gate_cnt  <= gate_cnt_nxt;
      occupancy <= occ_nxt;
    end
  end

  // Gate counter is loaded with GATE_CYCLES-1 so the open phase spans exactly GATE_CYCLES cycles.
  always_comb begin
    state_nxt    = state;
    gate_cnt_nxt = gate_cnt;
    occ_nxt      = occupancy;
    entry_ack    = 1'b0;
    exit_ack     = 1'b0;
    exit_err     = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          if (exit_req && occupancy[exit_slot]) begin
            exit_ack           = 1'b1;
            occ_nxt[exit_slot] = 1'b0;
            state_nxt          = EXIT_GATE;
            gate_cnt_nxt       = GW'(GATE_CYCLES - 1);
          end else begin
            exit_err = exit_req;
            if (entry_req && !full) begin
              entry_ack           = 1'b1;
              occ_nxt[empty_slot] = 1'b1;
              state_nxt           = ENTRY_GATE;
              gate_cnt_nxt        = GW'(GATE_CYCLES - 1);
            end
          end
        end
      end
      ENTRY_GATE, EXIT_GATE: begin
        if (gate_cnt == '0) state_nxt = IDLE;
        else                gate_cnt_nxt = gate_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A free slot's timer is held clear, which also zeroes it before admission.
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    slot_timer u_timer (
      .clk_500Hz (clk_500Hz),
      .clear     (reset || !occupancy[i] || (exit_ack && exit_slot == slot_idx_t'(i))),
      .run       (occupancy[i]),
      .tick      (tick),
      .minutes   (tm_min[i]),
      .seconds   (tm_sec[i])
    );
  end

  always_ff @(posedge clk_500Hz) begin
    if (reset) begin
      mode    <= 1'b0;
      minutes <= '0;
      seconds <= '0;
    end else begin
      mode    <= show_time;
      minutes <= tm_min[sel_slot];
      seconds <= tm_sec[sel_slot];
    end
  end

`ifdef PARKING_FEE_EN
  assign fee_valid = exit_ack;
  assign fee       = 8'(tm_min[exit_slot]) + 8'd1;
`endif

endmodule

// File: tb/tb_parking_controller.sv
// Self-checking bench for parking_controller with a cycle-level behavioural
// model (elapsed seconds per slot, gate busy time) and directed scenarios.
module tb_parking_controller;

  localparam int T  = 2;
  localparam int G  = 1;
  localparam int GC = T * G;

  logic       clk = 1'b0;
  logic       reset, entry_req, exit_req, show_time;
  logic [1:0] exit_slot, sel_slot;
  logic       gate_open, entry_ack, exit_ack, exit_err, full, mode;
  logic [3:0] occupancy;
  logic [2:0] capacity;
  logic [1:0] empty_slot;
  logic [5:0] minutes, seconds;
`ifdef PARKING_FEE_EN
  logic [7:0] fee;
  logic       fee_valid;
`endif

  always #5 clk = ~clk;

  parking_controller #(.TICKS_PER_SEC(T), .GATE_OPEN_SECS(G)) dut (
    .clk_500Hz (clk),
    .reset     (reset),
    .entry_req (entry_req),
    .exit_req  (exit_req),
    .exit_slot (exit_slot),
    .show_time (show_time),
    .sel_slot  (sel_slot),
    .gate_open (gate_open),
    .entry_ack (entry_ack),
    .exit_ack  (exit_ack),
    .exit_err  (exit_err),
    .full      (full),
    .occupancy (occupancy),
    .mode      (mode),
    .capacity  (capacity),
    .empty_slot(empty_slot),
    .minutes   (minutes),
    .seconds   (seconds)
`ifdef PARKING_FEE_EN
    ,
    .fee       (fee),
    .fee_valid (fee_valid)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: occupancy flags, elapsed seconds per slot, cycles since reset, gate time left.
  bit m_valid = 1'b0;
  bit m_occ [4];
  int m_el  [4];
  int m_k;
  int m_gate;
  bit m_mode;
  int m_min, m_sec;

  function automatic int n_free();
    int n = 0;
    for (int i = 0; i < 4; i++) if (!m_occ[i]) n++;
    return n;
  endfunction

  function automatic int first_free();
    for (int i = 0; i < 4; i++) if (!m_occ[i]) return i;
    return 0;
  endfunction

  function automatic bit m_vexit();
    return !reset && m_gate == 0 && exit_req && m_occ[exit_slot];
  endfunction

  function automatic bit m_verr();
    return !reset && m_gate == 0 && exit_req && !m_occ[exit_slot];
  endfunction

  function automatic bit m_ventry();
    return !reset && m_gate == 0 && entry_req && n_free() > 0 && !m_vexit();
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin m_occ[i] = 1'b0; m_el[i] = 0; end
      m_k = 0; m_gate = 0; m_mode = 1'b0; m_min = 0; m_sec = 0;
    end else if (m_valid) begin
      bit vx, ve, tk;
      int idx;
      vx = m_vexit();
      ve = m_ventry();
      idx = first_free();
      tk = (m_k % T) == T - 1;
      m_k++;
      m_mode = show_time;
      m_min = m_el[sel_slot] / 60;
      m_sec = m_el[sel_slot] % 60;
      if (tk)
        for (int i = 0; i < 4; i++)
          if (m_occ[i] && m_el[i] < 3599) m_el[i]++;
      if (vx) begin m_occ[exit_slot] = 1'b0; m_el[exit_slot] = 0; end
      if (ve) begin m_occ[idx] = 1'b1; m_el[idx] = 0; end
      if (m_gate > 0) m_gate--;
      else if (vx || ve) m_gate = GC;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic [3:0] po;
      for (int i = 0; i < 4; i++) po[i] = m_occ[i];
      chk("gate_open",  gate_open,  m_gate > 0);
      chk("entry_ack",  entry_ack,  m_ventry());
      chk("exit_ack",   exit_ack,   m_vexit());
      chk("exit_err",   exit_err,   m_verr());
      chk("occupancy",  occupancy,  po);
      chk("capacity",   capacity,   n_free());
      chk("full",       full,       n_free() == 0);
      chk("empty_slot", empty_slot, first_free());
      chk("mode",       mode,       m_mode);
      chk("minutes",    minutes,    m_min);
      chk("seconds",    seconds,    m_sec);
`ifdef PARKING_FEE_EN
      chk("fee_valid",  fee_valid,  m_vexit());
      if (m_vexit()) chk("fee", fee, m_el[exit_slot] / 60 + 1);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic wait_entry(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (entry_ack) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (!gate_open) return;
      step();
    end
    chk("wait_idle_timeout", 1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, 0 expected hangs");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, seen;
    int edges;
    reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0; exit_slot = '0;
    show_time = 1'b0; sel_slot = '0;
    do_reset();
    #1;
    chk("rst_capacity", capacity, 4);
    chk("rst_full", full, 0);
    chk("rst_empty_slot", empty_slot, 0);
    chk("rst_gate_open", gate_open, 0);
    chk("rst_mode", mode, 0);
    chk("rst_minutes", minutes, 0);

    // four admissions fill slots 0..3 in order
    entry_req = 1'b1;
    for (int s = 0; s < 4; s++) begin
      wait_entry(ok);
      chk("entry_seen", ok, 1);
      chk("alloc_slot", empty_slot, s);
      chk("cap_before_ack", capacity, 4 - s);
      step();
      chk("cap_after_ack", capacity, 3 - s);
    end
    chk("full_set", full, 1);
    chk("empty_when_full", empty_slot, 0);

    seen = 1'b0;
    repeat (8) begin step(); #1; if (entry_ack) seen = 1'b1; end
    chk("held_while_full", seen, 0);

    exit_req = 1'b1; exit_slot = 2'd2;
    #1;
    chk("exit_ack_slot2", exit_ack, 1);
    chk("entry_blocked_by_exit", entry_ack, 0);
    step();
    exit_req = 1'b0;
    chk("cap_after_exit", capacity, 1);
    chk("empty_after_exit", empty_slot, 2);
    wait_entry(ok);
    chk("held_entry_admitted", ok, 1);
    chk("readmit_slot", empty_slot, 2);
    step();
    chk("full_again", full, 1);

    // simultaneous entry and exit: exit first, entry after the gate
    wait_idle();
    exit_req = 1'b1; exit_slot = 2'd1;
    #1;
    chk("simul_exit_ack", exit_ack, 1);
    chk("simul_entry_ack", entry_ack, 0);
    step();
    exit_req = 1'b0;
    edges = 1;
    #1;
    while (!entry_ack && edges < 20) begin step(); edges++; #1; end
    chk("exit_then_entry_edges", edges, 3);
    chk("entry_into_slot1", empty_slot, 1);
    step();
    entry_req = 1'b0;

    // exit from a free slot
    wait_idle();
    exit_req = 1'b1; exit_slot = 2'd3;
    #1;
    chk("exit_slot3_ack", exit_ack, 1);
    step();
    exit_req = 1'b0;
    wait_idle();
    exit_req = 1'b1; exit_slot = 2'd3;
    #1;
    chk("exit_err_free", exit_err, 1);
    chk("no_ack_free", exit_ack, 0);
    step();
    exit_req = 1'b0;
    #1;
    chk("err_gate_closed", gate_open, 0);
    chk("err_occ_kept", occupancy, 4'b0111);
    chk("err_one_cycle", exit_err, 0);

    // 121 s in slot 0
    do_reset();
    entry_req = 1'b1;
    #1;
    chk("t121_entry", entry_ack, 1);
    step();
    entry_req = 1'b0; show_time = 1'b1; sel_slot = 2'd0;
    repeat (242) step();
    chk("t121_mode", mode, 1);
    chk("t121_minutes", minutes, 2);
    chk("t121_seconds", seconds, 1);
`ifdef PARKING_FEE_EN
    exit_req = 1'b1; exit_slot = 2'd0;
    #1;
    chk("fee_valid_pulse", fee_valid, 1);
    chk("fee_value", fee, 3);
    step();
    exit_req = 1'b0;
`endif

    // reset during the entry gate
    do_reset();
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    chk("gate_open_before_rst", gate_open, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_gate_closed", gate_open, 0);
    chk("rst_mid_gate_cap", capacity, 4);
    step(); step();
    chk("rst_mid_gate_min", minutes, 0);
    chk("rst_mid_gate_sec", seconds, 0);

    // slot 0 held past an hour saturates at 59:59
    do_reset();
    entry_req = 1'b1;
    step();
    show_time = 1'b1; sel_slot = 2'd0;
    repeat (7300) begin
      entry_req = ($urandom_range(0, 3) == 0);
      step();
    end
    entry_req = 1'b0;
    step();
    chk("sat_minutes", minutes, 59);
    chk("sat_seconds", seconds, 59);

    // random traffic
    repeat (4000) begin
      entry_req = $urandom_range(0, 1);
      exit_req  = ($urandom_range(0, 3) == 0);
      exit_slot = 2'($urandom_range(0, 3));
      show_time = $urandom_range(0, 1);
      sel_slot  = 2'($urandom_range(0, 3));
      reset     = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; entry_req = 1'b0; exit_req = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
